// File: rtl/noc_packet_injector.sv
`timescale 1ns/1ps
// noc_packet_injector: buffers PE words in a small FIFO, stamps them with this
// node's address and sends each one to a tree input port over a 4-phase
// bundled-data req/ack handshake.
module noc_packet_injector #(
   parameter int unsigned           WIDTH_packet = 14,
   parameter int unsigned           WIDTH_dest   = 3,
   parameter int unsigned           WIDTH_addr   = 3,
   parameter logic [WIDTH_addr-1:0] ADDR         = 3'b000,
   parameter int unsigned           DEPTH        = 4
) (
   input  logic                                        clk,
   input  logic                                        rst_n,
   input  logic                                        in_valid,
   output logic                                        in_ready,
   input  logic [WIDTH_dest-1:0]                       in_dest,
   input  logic [WIDTH_packet-WIDTH_dest-WIDTH_addr-1:0] in_payload,
   output logic                                        out_req,
   input  logic                                        out_ack,
   output logic [WIDTH_packet-1:0]                     out_data,
   output logic                                        busy,
   output logic [15:0]                                 pkt_count
);

   localparam int unsigned WIDTH_pay  = WIDTH_packet - WIDTH_dest - WIDTH_addr;
   localparam int unsigned WIDTH_word = WIDTH_dest + WIDTH_pay;
   localparam int unsigned AW         = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_REQ, S_RELEASE} state_t;

   // FIFO storage and pointers; pointers carry one extra wrap bit so that
   // full and empty are distinguishable without a separate counter.
   logic [WIDTH_word-1:0] r_mem [DEPTH];
   logic [AW:0]           r_wr_ptr;
   logic [AW:0]           r_rd_ptr;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_pop;
   logic [WIDTH_word-1:0] w_head;

   // Acknowledge synchronizer.
   logic r_ack_meta;
   logic r_ack_s;

   // Handshake FSM and outputs.
   state_t                  r_state;
   state_t                  w_state_nxt;
   logic                    r_req;
   logic                    w_req_nxt;
   logic                    w_count_inc;
   logic [WIDTH_packet-1:0] r_data;
   logic [15:0]             r_pkt_count;

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push  = in_valid && !w_full;
   assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

   assign in_ready  = !w_full;
   assign out_req   = r_req;
   assign out_data  = r_data;
   assign pkt_count = r_pkt_count;
   assign busy      = !w_empty || (r_state != S_IDLE);

   // FIFO data write; contents are only ever read behind a valid pointer.
   // NOTE: storage arrays get no reset -- the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= {in_dest, in_payload};
      end
   end

   // FIFO pointer update; push and pop may happen in the same cycle.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   // Two-flop synchronizer for the acknowledge coming from the tree.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ack_meta <= 1'b0;
         r_ack_s    <= 1'b0;
      end else begin
         r_ack_meta <= out_ack;
         r_ack_s    <= r_ack_meta;
      end
   end

   // Handshake next-state, request and pop decode.
   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_req_nxt   = 1'b0;
      w_pop       = 1'b0;
      w_count_inc = 1'b0;
      case (r_state)
         S_IDLE: begin
            // Waiting for ack_s low also absorbs an ack left high by a reset.
            if (!w_empty && !r_ack_s) begin
               w_pop       = 1'b1;
               w_state_nxt = S_SETUP;
            end
         end
         S_SETUP: begin
            w_state_nxt = S_REQ;
            w_req_nxt   = 1'b1;
         end
         S_REQ: begin
            if (r_ack_s) w_state_nxt = S_RELEASE;
            else         w_req_nxt   = 1'b1;
         end
         S_RELEASE: begin
            if (!r_ack_s) begin
               w_state_nxt = S_IDLE;
               w_count_inc = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Handshake state, registered request, packet register and counter.
   // out_req is a flop so it is glitch-free and drops on reset assertion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_req       <= 1'b0;
         r_data      <= '0;
         r_pkt_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_req   <= w_req_nxt;
         if (w_pop) begin
            r_data <= {w_head[WIDTH_word-1 -: WIDTH_dest], ADDR, w_head[WIDTH_pay-1:0]};
         end
         if (w_count_inc) r_pkt_count <= r_pkt_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_noc_packet_injector.sv
`timescale 1ns/1ps
// Self-checking bench for noc_packet_injector: table-driven single packets,
// a scoreboard on every request rise, and hand-written corner sequences.
module tb_noc_packet_injector;

   localparam logic [2:0] ADDR  = 3'b100;
   localparam int         DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_dest;
   logic [7:0]  in_payload;
   logic        out_req;
   wire         out_ack;
   logic [13:0] out_data;
   logic        busy;
   logic [15:0] pkt_count;

   // Tree side: an automatic responder or a manually driven ack.
   logic        ack_en;
   logic        ack_auto;
   logic        ack_manual;
   int unsigned ack_dly_max;
   assign out_ack = ack_en ? ack_auto : ack_manual;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [13:0] sb_q[$];
   int          stab_viol = 0;
   time         t_req_fall = 0;
   time         t_rst = 0;

   typedef struct {
      logic [2:0]  dest;
      logic [7:0]  payload;
      logic [13:0] exp_pkt;
   } vec_t;
   vec_t vecs[5];

   always #5 clk = ~clk;

   noc_packet_injector #(
      .WIDTH_packet (14),
      .WIDTH_dest   (3),
      .WIDTH_addr   (3),
      .ADDR         (ADDR),
      .DEPTH        (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_dest    (in_dest),
      .in_payload (in_payload),
      .out_req    (out_req),
      .out_ack    (out_ack),
      .out_data   (out_data),
      .busy       (busy),
      .pkt_count  (pkt_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
   endtask

   // Scoreboard: every request rise must carry the oldest outstanding word.
   always @(posedge out_req) begin
      #1;
      if (sb_q.size() == 0) begin
         n_checks++;
         $display("FAIL unexpected_pkt: got 0x%0h, required no packet", out_data);
      end else begin
         check("pkt_order", {18'd0, out_data}, {18'd0, sb_q.pop_front()});
      end
   end

   // Bundled-data rule: data must not move while req or ack is high.
   always @(out_data) begin
      if (rst_n === 1'b1 && (out_req === 1'b1 || out_ack === 1'b1)) stab_viol++;
   end

   always @(negedge out_req) t_req_fall = $time;

   // Automatic tree responder with random delays, asynchronous to clk.
   initial begin
      ack_auto = 1'b0;
      forever begin
         #1;
         if (ack_en) begin
            if (out_req && !ack_auto) begin
               #($urandom_range(ack_dly_max, 0));
               ack_auto = 1'b1;
            end else if (!out_req && ack_auto) begin
               #($urandom_range(ack_dly_max, 0));
               ack_auto = 1'b0;
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic apply_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      sb_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic push_word(input logic [2:0] d, input logic [7:0] p);
      int n = 0;
      @(negedge clk);
      in_valid   = 1'b1;
      in_dest    = d;
      in_payload = p;
      while (!in_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("push_timeout", {31'd0, in_ready}, 32'd1);
         in_valid = 1'b0;
         return;
      end
      sb_q.push_back({d, ADDR, p});
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_req(input logic val, input string name);
      int n = 0;
      @(negedge clk);
      while (out_req !== val && n < 100) begin
         @(negedge clk);
         n++;
      end
      check(name, {31'd0, out_req}, {31'd0, val});
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      @(negedge clk);
      while ((busy || sb_q.size() != 0) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check(name, {31'd0, busy}, 32'd0);
      check({name, "_sb"}, sb_q.size(), 32'd0);
   endtask

   initial begin
      int base;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_dest     = '0;
      in_payload  = '0;
      ack_en      = 1'b0;
      ack_manual  = 1'b0;
      ack_dly_max = 3;

      vecs[0] = '{3'b101, 8'hFE, 14'b101_100_11111110};
      vecs[1] = '{3'b000, 8'h00, 14'b000_100_00000000};
      vecs[2] = '{3'b111, 8'hFF, 14'b111_100_11111111};
      vecs[3] = '{3'b100, 8'hA5, 14'b100_100_10100101};
      vecs[4] = '{3'b010, 8'h3C, 14'b010_100_00111100};

      // Reset values.
      apply_reset();
      @(negedge clk);
      check("rst_out_req",   {31'd0, out_req},   32'd0);
      check("rst_out_data",  {18'd0, out_data},  32'd0);
      check("rst_in_ready",  {31'd0, in_ready},  32'd1);
      check("rst_busy",      {31'd0, busy},      32'd0);
      check("rst_pkt_count", {16'd0, pkt_count}, 32'd0);

      // Table-driven single packets with exact latency.
      ack_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid   = 1'b1;
         in_dest    = vecs[i].dest;
         in_payload = vecs[i].payload;
         sb_q.push_back(vecs[i].exp_pkt);
         @(posedge clk);
         #1 in_valid = 1'b0;
         @(negedge clk);
         check("vec_busy_after_push", {31'd0, busy}, 32'd1);
         check("vec_req_idle", {31'd0, out_req}, 32'd0);
         @(negedge clk);
         check("vec_req_setup", {31'd0, out_req}, 32'd0);
         check("vec_setup_data", {18'd0, out_data}, {18'd0, vecs[i].exp_pkt});
         @(negedge clk);
         check("vec_req_rise", {31'd0, out_req}, 32'd1);
         wait_drain("vec_drain");
         check("vec_count", {16'd0, pkt_count}, i + 1);
         check("vec_data_hold", {18'd0, out_data}, {18'd0, vecs[i].exp_pkt});
      end

      // Full FIFO behind a stalled ack: one word in flight plus DEPTH queued.
      ack_en     = 1'b0;
      ack_manual = 1'b0;
      apply_reset();
      for (int i = 0; i < 5; i++) push_word(3'(i), 8'(8'h10 + i));
      @(negedge clk);
      check("full_ready", {31'd0, in_ready}, 32'd0);
      check("full_req_held", {31'd0, out_req}, 32'd1);
      in_valid   = 1'b1;
      in_dest    = 3'b111;
      in_payload = 8'h66;
      repeat (3) @(negedge clk);
      check("full_refuse", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b0;
      ack_en   = 1'b1;
      wait_drain("full_drain");
      check("full_count", {16'd0, pkt_count}, 32'd5);

      // Push and pop in the same cycle with DEPTH-1 words queued.
      ack_en     = 1'b0;
      ack_manual = 1'b0;
      apply_reset();
      for (int i = 0; i < 4; i++) push_word(3'(i), 8'(8'h20 + i));
      wait_req(1'b1, "pp_req_up");
      check("pp_ready_pre", {31'd0, in_ready}, 32'd1);
      ack_manual = 1'b1;
      wait_req(1'b0, "pp_req_fall");
      ack_manual = 1'b0;
      // Two synchronizer edges, one RELEASE->IDLE edge, then the pop edge.
      repeat (3) @(posedge clk);
      @(negedge clk);
      in_valid   = 1'b1;
      in_dest    = 3'b011;
      in_payload = 8'h5A;
      sb_q.push_back({3'b011, ADDR, 8'h5A});
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check("pp_ready_post", {31'd0, in_ready}, 32'd1);
      check("pp_setup_data", {18'd0, out_data}, {18'd0, 3'b001, ADDR, 8'h21});
      push_word(3'b110, 8'h77);
      @(negedge clk);
      check("pp_full", {31'd0, in_ready}, 32'd0);
      ack_en = 1'b1;
      wait_drain("pp_drain");
      check("pp_count", {16'd0, pkt_count}, 32'd6);

      // Slow and irregular ack.
      ack_dly_max = 20;
      base = int'(pkt_count);
      for (int i = 0; i < 20; i++) begin
         push_word(3'($urandom_range(7, 0)), 8'($urandom_range(255, 0)));
      end
      wait_drain("irr_drain");
      check("irr_count", {16'd0, pkt_count}, base + 20);
      check("irr_stable", stab_viol, 32'd0);

      // Reset while in REQ with the ack still high across reset release.
      ack_dly_max = 3;
      ack_en      = 1'b0;
      ack_manual  = 1'b0;
      push_word(3'b010, 8'hC3);
      push_word(3'b011, 8'hC4);
      wait_req(1'b1, "rst_req_up");
      ack_manual = 1'b1;
      #2;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      t_rst    = $time;
      #1;
      check("rst_req_async", t_req_fall[31:0], t_rst[31:0]);
      check("rst_req_low", {31'd0, out_req}, 32'd0);
      sb_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst2_count", {16'd0, pkt_count}, 32'd0);
      check("rst2_busy", {31'd0, busy}, 32'd0);
      check("rst2_ready", {31'd0, in_ready}, 32'd1);
      repeat (3) @(negedge clk);
      push_word(3'b001, 8'h99);
      repeat (10) @(negedge clk);
      check("rst2_no_req", {31'd0, out_req}, 32'd0);
      check("rst2_busy_wait", {31'd0, busy}, 32'd1);
      ack_manual = 1'b0;
      ack_en     = 1'b1;
      wait_drain("rst2_drain");
      check("rst2_resume_count", {16'd0, pkt_count}, 32'd1);

      // Counter wrap.
      @(negedge clk);
      force dut.r_pkt_count = 16'hFFFF;
      @(negedge clk);
      release dut.r_pkt_count;
      @(negedge clk);
      check("wrap_preload", {16'd0, pkt_count}, 32'h0000_FFFF);
      push_word(3'b111, 8'h01);
      wait_drain("wrap_drain");
      check("wrap_count", {16'd0, pkt_count}, 32'd0);

      check("stable_all", stab_viol, 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
